reorder_buffer: RTL

REORDER_BUFFER -- requirements
Module: reorder_buffer

---
 rtl/reorder_buffer_pkg.sv | 25 ++
 rtl/rob_pointer.sv | 36 +++
 rtl/reorder_buffer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared types and default sizes for the reorder buffer.
package reorder_buffer_pkg;

    localparam int unsigned ROB_WIDTH_DEF = 4;
    localparam int unsigned REG_WIDTH_DEF = 5;
    localparam int unsigned DATA_WIDTH    = 32;
    // Destination storage is sized for the widest register index supported.
    localparam int unsigned REG_IDX_MAX_W = 8;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ISSUED = 2'd1,
        ST_DONE   = 2'd2
    } entry_state_e;

    typedef struct packed {
        entry_state_e             state;
        logic [REG_IDX_MAX_W-1:0] dest;
        logic [DATA_WIDTH-1:0]    data;
        logic                     is_branch;
        logic                     predict;
        logic                     taken;
    } rob_entry_t;

endpackage

// File: rtl/rob_pointer.sv
// Wrapping pointer with increment and synchronous clear; clear wins.
module rob_pointer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] ptr_o
);

    logic [WIDTH-1:0] ptr_q;
    logic [WIDTH-1:0] ptr_d;

    // Next pointer value; natural overflow gives the wrap to zero.
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + WIDTH'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer with branch misprediction flush.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int unsigned ROB_WIDTH = ROB_WIDTH_DEF,
    parameter int unsigned REG_WIDTH = REG_WIDTH_DEF
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  rdyIn,
    input  logic                  issueFlag,
    input  logic [REG_WIDTH-1:0]  issueReg,
    input  logic                  issueBranch,
    input  logic                  issuePredict,
    output logic [ROB_WIDTH-1:0]  issueROB,
    output logic                  robFull,
    input  logic                  wbFlag,
    input  logic [ROB_WIDTH-1:0]  wbROB,
    input  logic [DATA_WIDTH-1:0] wbData,
    input  logic                  wbTaken,
    output logic                  writeFlag,
    output logic [ROB_WIDTH-1:0]  writeSrc,
    output logic [REG_WIDTH-1:0]  writeReg,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  clrOut
);

    localparam int unsigned DEPTH = 1 << ROB_WIDTH;
    localparam int unsigned CNT_W = ROB_WIDTH + 1;

    rob_entry_t entries_q [DEPTH];
    rob_entry_t entries_d [DEPTH];

    logic [CNT_W-1:0]      count_q;
    logic [CNT_W-1:0]      count_d;
    logic [ROB_WIDTH-1:0]  head_q;
    logic [ROB_WIDTH-1:0]  tail_q;

    logic                  write_flag_q;
    logic                  write_flag_d;
    logic [ROB_WIDTH-1:0]  write_src_q;
    logic [ROB_WIDTH-1:0]  write_src_d;
    logic [REG_WIDTH-1:0]  write_reg_q;
    logic [REG_WIDTH-1:0]  write_reg_d;
    logic [DATA_WIDTH-1:0] write_data_q;
    logic [DATA_WIDTH-1:0] write_data_d;
    logic                  clr_q;
    logic                  clr_d;

    rob_entry_t            head_ent_c;
    logic                  full_c;
    logic                  commit_c;
    logic                  mispredict_c;
    logic                  issue_c;
    logic                  wb_c;

    // Event decode, all from pre-edge state.
    always_comb begin
        head_ent_c   = entries_q[head_q];
        full_c       = (count_q == CNT_W'(DEPTH));
        commit_c     = rdyIn && (count_q != '0) && (head_ent_c.state == ST_DONE);
        mispredict_c = commit_c && head_ent_c.is_branch
                       && (head_ent_c.taken != head_ent_c.predict);
        issue_c      = rdyIn && issueFlag && !full_c && !mispredict_c;
        wb_c         = rdyIn && wbFlag && !mispredict_c
                       && (entries_q[wbROB].state == ST_ISSUED);
    end

    // Entry array update: flush, or commit/writeback/issue on distinct slots.
    always_comb begin
        entries_d = entries_q;
        if (mispredict_c) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
        end else begin
            if (commit_c) begin
                entries_d[head_q].state = ST_EMPTY;
            end
            if (wb_c) begin
                entries_d[wbROB].state = ST_DONE;
                entries_d[wbROB].data  = wbData;
                entries_d[wbROB].taken = wbTaken;
            end
            if (issue_c) begin
                entries_d[tail_q].state     = ST_ISSUED;
                entries_d[tail_q].dest      = REG_IDX_MAX_W'(issueReg);
                entries_d[tail_q].data      = '0;
                entries_d[tail_q].is_branch = issueBranch;
                entries_d[tail_q].predict   = issuePredict;
                entries_d[tail_q].taken     = 1'b0;
            end
        end
    end

    // Occupancy count; simultaneous issue and commit cancel out.
    always_comb begin
        count_d = count_q;
        if (mispredict_c) begin
            count_d = '0;
        end else if (issue_c && !commit_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!issue_c && commit_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Commit port and flush pulse next-state; payload holds between commits.
    always_comb begin
        write_flag_d = commit_c && !head_ent_c.is_branch;
        write_src_d  = write_src_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        clr_d        = mispredict_c;
        if (commit_c && !head_ent_c.is_branch) begin
            write_src_d  = head_q;
            write_reg_d  = REG_WIDTH'(head_ent_c.dest);
            write_data_d = head_ent_c.data;
        end
    end

    // Entry storage and count registers.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= entries_d[i];
            end
            count_q <= count_d;
        end
    end

    // Registered commit and flush outputs.
    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            write_flag_q <= 1'b0;
            write_src_q  <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            clr_q        <= 1'b0;
        end else begin
            write_flag_q <= write_flag_d;
            write_src_q  <= write_src_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            clr_q        <= clr_d;
        end
    end

    rob_pointer #(
        .WIDTH (ROB_WIDTH)
    ) u_head (
        .clk_i (clkIn),
        .rst_i (rstIn),
        .inc_i (commit_c && !mispredict_c),
        .clr_i (mispredict_c),
        .ptr_o (head_q)
    );

    rob_pointer #(
        .WIDTH (ROB_WIDTH)
    ) u_tail (
        .clk_i (clkIn),
        .rst_i (rstIn),
        .inc_i (issue_c),
        .clr_i (mispredict_c),
        .ptr_o (tail_q)
    );

    assign issueROB  = tail_q;
    assign robFull   = full_c;
    assign writeFlag = write_flag_q;
    assign writeSrc  = write_src_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign clrOut    = clr_q;

endmodule
